// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Hardware program loader: the writer side of the instruction memory.
//   It takes a byte stream over a valid/ready link and assembles 32-bit
//   little-endian words. Each word goes to the instruction memory write port.
//   The core is held in reset while a load is in progress. After the last
//   word is written, the core is released and runs from PC 0.
//
//   Stream format: LEN[7:0], LEN[15:8], then 4*LEN data bytes (LSB first).
//
// Ports
//   clk         system clock, posedge
//   rst         synchronous, active-high reset
//   start       1-cycle pulse, begins a new load (honoured in IDLE and RUN)
//   rx_data     stream byte
//   rx_valid    rx_data valid
//   rx_ready    loader can accept a byte
//   imem_we     instruction memory write strobe (one cycle per word)
//   imem_waddr  word address of the write (holds when imem_we=0)
//   imem_wdata  word being written (holds when imem_we=0)
//   core_rst    active-high core reset, high whenever not in RUN
//   load_done   high in RUN
//   err_len     sticky: last header length exceeded capacity
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              err_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_RUN
  } state_t;

  // Capacity in words, held one bit wider than the address so that a full
  // load (len == 2**ADDR_W) is representable without wrapping.
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t            state, state_n;
  logic [15:0]       len;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_word;   // bytes 0..2; byte 3 goes straight to imem_wdata
  logic [15:0]       len_full;
  logic              len_too_big;
  logic              last_word;

  function automatic logic [16:0] ext17(input logic [ADDR_W:0] v);
    return 17'(v);
  endfunction

  // Length as it will be once the high byte currently on rx_data is taken.
  assign len_full    = {rx_data, len[7:0]};
  assign len_too_big = ({1'b0, len_full} > CAP);
  assign last_word   = ((ext17(word_cnt) + 17'd1) == {1'b0, len});

  always_comb begin
    state_n   = state;
    rx_ready  = 1'b0;
    imem_we   = 1'b0;
    core_rst  = 1'b1;
    load_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (len_full == 16'd0)   state_n = S_RUN;
          else if (len_too_big)    state_n = S_IDLE;
          else                     state_n = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && (byte_cnt == 2'd3)) state_n = S_WRITE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        state_n = last_word ? S_RUN : S_DATA;
      end
      S_RUN: begin
        core_rst  = 1'b0;
        load_done = 1'b1;
        if (start) state_n = S_LEN_LO;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      asm_word   <= '0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      err_len    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE, S_RUN: begin
          if (start) err_len <= 1'b0;
        end
        S_LEN_LO: begin
          if (rx_valid) len[7:0] <= rx_data;
        end
        S_LEN_HI: begin
          if (rx_valid) begin
            len[15:8] <= rx_data;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            if (len_too_big) err_len <= 1'b1;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            case (byte_cnt)
              2'd0: asm_word[7:0]   <= rx_data;
              2'd1: asm_word[15:8]  <= rx_data;
              2'd2: asm_word[23:16] <= rx_data;
              default: begin
                // Address/data registered here so they are stable during
                // WRITE and hold afterwards.
                imem_waddr <= word_cnt[ADDR_W-1:0];
                imem_wdata <= {rx_data, asm_word};
              end
            endcase
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
          byte_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              err_len;

  int checks = 0;
  int errors = 0;

  // Write log, filled from the memory-port side.
  logic [31:0] wd_log [0:511];
  logic [31:0] wa_log [0:511];
  int          wcount = 0;
  int          base;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wcount < 512) begin
        wa_log[wcount] = 32'(imem_waddr);
        wd_log[wcount] = imem_wdata;
      end
      wcount = wcount + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a byte and hold it until the loader takes it; rx_valid stays
  // high on return so back-to-back calls stream continuously.
  task automatic send(input logic [7:0] b);
    bit done;
    done = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (rx_ready) done = 1'b1;
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=ready_low expected=accept byte=%0h", b);
    end
  endtask

  task automatic send_gap(input logic [7:0] b);
    send(b);
    rx_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

    // 1. reset
    tick(); tick();
    check("rst_core_rst", core_rst, 1);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_load_done", load_done, 0);
    check("rst_err_len", err_len, 0);
    check("rst_waddr", imem_waddr, 0);
    check("rst_wdata", imem_wdata, 0);
    rst = 1'b0;
    tick();
    check("idle_ready", rx_ready, 0);

    // 2. two-word load, continuous valid
    base = wcount;
    pulse_start();
    check("t2_lenlo_ready", rx_ready, 1);
    send(8'h02); send(8'h00);
    send(8'h93); send(8'h00); send(8'hA0); send(8'h00);
    check("t2_write0_we", imem_we, 1);
    check("t2_write0_addr", imem_waddr, 0);
    check("t2_write0_data", imem_wdata, 32'h00A00093);
    check("t2_write0_ready", rx_ready, 0);
    send(8'h13); send(8'h01); send(8'h50); send(8'h00);
    rx_valid = 1'b0;
    check("t2_write1_we", imem_we, 1);
    check("t2_write1_core_rst", core_rst, 1);
    tick();
    check("t2_run_core_rst", core_rst, 0);
    check("t2_run_done", load_done, 1);
    check("t2_run_we", imem_we, 0);
    check("t2_hold_addr", imem_waddr, 1);
    check("t2_hold_data", imem_wdata, 32'h00500113);
    tick();
    check("t2_nwrites", wcount - base, 2);
    check("t2_a0", wa_log[base], 0);
    check("t2_d0", wd_log[base], 32'h00A00093);
    check("t2_a1", wa_log[base+1], 1);
    check("t2_d1", wd_log[base+1], 32'h00500113);

    // 3. same load with gaps; a start pulse mid-load must be ignored
    base = wcount;
    pulse_start();
    check("t3_core_rst", core_rst, 1);
    check("t3_done", load_done, 0);
    send_gap(8'h02); send_gap(8'h00);
    send(8'h93);
    rx_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    send_gap(8'h00); send_gap(8'hA0); send_gap(8'h00);
    send_gap(8'h13); send_gap(8'h01); send_gap(8'h50);
    send(8'h00);
    rx_valid = 1'b0;
    tick();
    check("t3_run_done", load_done, 1);
    tick();
    check("t3_nwrites", wcount - base, 2);
    check("t3_a0", wa_log[base], 0);
    check("t3_d0", wd_log[base], 32'h00A00093);
    check("t3_a1", wa_log[base+1], 1);
    check("t3_d1", wd_log[base+1], 32'h00500113);

    // 4. zero-length load
    base = wcount;
    pulse_start();
    send(8'h00); send(8'h00);
    rx_valid = 1'b0;
    check("t4_run_done", load_done, 1);
    check("t4_core_rst", core_rst, 0);
    tick(); tick();
    check("t4_nwrites", wcount - base, 0);

    // 5. oversize length (257)
    base = wcount;
    pulse_start();
    send(8'h01); send(8'h01);
    rx_valid = 1'b0;
    check("t5_err_len", err_len, 1);
    check("t5_core_rst", core_rst, 1);
    check("t5_ready", rx_ready, 0);
    check("t5_done", load_done, 0);
    tick(); tick();
    check("t5_nwrites", wcount - base, 0);
    check("t5_err_sticky", err_len, 1);

    // 6. reset in the middle of word 1, then a fresh one-word load
    base = wcount;
    pulse_start();
    check("t6_err_clear", err_len, 0);
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66);
    rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_core_rst", core_rst, 1);
    check("t6_rst_ready", rx_ready, 0);
    check("t6_rst_waddr", imem_waddr, 0);
    check("t6_rst_wdata", imem_wdata, 0);
    tick(); tick(); tick();
    check("t6_nwrites_partial", wcount - base, 1);
    check("t6_d0", wd_log[base], 32'h44332211);
    base = wcount;
    pulse_start();
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    rx_valid = 1'b0;
    tick();
    check("t6_run_done", load_done, 1);
    tick();
    check("t6_nwrites", wcount - base, 1);
    check("t6_fresh_a0", wa_log[base], 0);
    check("t6_fresh_d0", wd_log[base], 32'h12345678);

    // 7. full-capacity load (256 words), no wrap
    base = wcount;
    pulse_start();
    send(8'h00); send(8'h01);
    check("t7_no_err", err_len, 0);
    for (int i = 0; i < 256; i++) begin
      send(8'(i)); send(8'h00); send(8'h00); send(8'hC0);
    end
    rx_valid = 1'b0;
    tick();
    check("t7_run_done", load_done, 1);
    check("t7_core_rst", core_rst, 0);
    tick();
    check("t7_nwrites", wcount - base, 256);
    check("t7_first_addr", wa_log[base], 0);
    check("t7_first_data", wd_log[base], 32'hC0000000);
    check("t7_last_addr", wa_log[base+255], 255);
    check("t7_last_data", wd_log[base+255], 32'hC00000FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
